// File: rtl/dotmatrix_scan_ctrl.sv
// Dot-matrix LED scan controller.
// Double-buffered frame store (front bank displayed, back bank written), row
// multiplexing with an anti-ghosting blank at the start of every row slot, and
// a per-frame brightness duty. Banks are swapped only at a frame boundary so a
// frame is never displayed half old and half new.
module dotmatrix_scan_ctrl #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int SCAN_DIV      = 22500,
  parameter int BLANK_CYC     = 16,
  parameter int SCAN_ACT_HIGH = 1,
  parameter int DATA_ACT_LOW  = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_addr,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  input  logic [3:0]              brightness,
  output logic                    swap_ack,
  output logic                    frame_start,
  output logic [ROWS-1:0]         Scan_LED,
  output logic [COLS-1:0]         Data_LED
);

  localparam int CW   = $clog2(SCAN_DIV);
  localparam int AW   = $clog2(ROWS);
  localparam int STEP = (SCAN_DIV - BLANK_CYC) / 16;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
  localparam logic [AW-1:0] ROW_ONE  = AW'(1);
  localparam logic [31:0]   BLANK_U  = 32'(BLANK_CYC);
  localparam logic [31:0]   STEP_U   = 32'(STEP);
  localparam logic [31:0]   ROWS_U   = 32'(ROWS);

  // Polarity masks: XOR with these turns a "1 = asserted / lit" view into pin levels.
  localparam logic            SCAN_INV  = (SCAN_ACT_HIGH == 0);
  localparam logic            DATA_INV  = (DATA_ACT_LOW != 0);
  localparam logic [ROWS-1:0] SCAN_IDLE = {ROWS{SCAN_INV}};
  localparam logic [COLS-1:0] DATA_IDLE = {COLS{DATA_INV}};

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } phase_t;

  logic [CW-1:0]   cnt_r;
  logic [AW-1:0]   row_r;
  logic            front_sel_r;
  logic            pending_r;
  logic [3:0]      bl_r;
  logic [COLS-1:0] bank0_r [ROWS];
  logic [COLS-1:0] bank1_r [ROWS];

  logic            frame_first_s;
  logic            frame_last_s;
  logic [3:0]      bl_eff_s;
  logic [31:0]     cnt_ext_s;
  logic [31:0]     on_len_s;
  phase_t          phase_s;
  logic [COLS-1:0] row_data_s;
  logic [ROWS-1:0] row_onehot_s;
  logic            wr_ok_s;

  assign frame_first_s = enable && (cnt_r == {CW{1'b0}}) && (row_r == {AW{1'b0}});
  assign frame_last_s  = enable && (cnt_r == CNT_LAST) && (row_r == ROW_LAST);
  assign cnt_ext_s     = {{(32-CW){1'b0}}, cnt_r};
  assign row_onehot_s  = {{(ROWS-1){1'b0}}, 1'b1} << row_r;
  assign wr_ok_s       = ({{(32-AW){1'b0}}, wr_addr} < ROWS_U);

  // Brightness in force for this cycle: the frame's first cycle already uses the newly latched value.
  always_comb begin
    bl_eff_s = bl_r;
    if (frame_first_s) begin
      bl_eff_s = brightness;
    end else begin
      bl_eff_s = bl_r;
    end
  end

  // Classify the current slot cycle as blank, lit or dark.
  always_comb begin
    on_len_s = {28'd0, bl_eff_s} * STEP_U;
    phase_s  = PH_BLANK;
    if (!enable) begin
      phase_s = PH_BLANK;
    end else if (cnt_ext_s < BLANK_U) begin
      phase_s = PH_BLANK;
    end else if ((cnt_ext_s - BLANK_U) < on_len_s) begin
      phase_s = PH_ON;
    end else begin
      phase_s = PH_OFF;
    end
  end

  // Fetch the displayed row from whichever bank is currently in front.
  always_comb begin
    row_data_s = {COLS{1'b0}};
    if (front_sel_r) begin
      row_data_s = bank1_r[row_r];
    end else begin
      row_data_s = bank0_r[row_r];
    end
  end

  // Slot counter, row index, brightness latch, swap handshake and frame pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r       <= {CW{1'b0}};
      row_r       <= {AW{1'b0}};
      front_sel_r <= 1'b0;
      pending_r   <= 1'b0;
      bl_r        <= 4'd0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_first_s;
      swap_ack    <= 1'b0;
      if (frame_first_s) begin
        bl_r <= brightness;
      end
      if (!enable) begin
        cnt_r <= {CW{1'b0}};
        row_r <= {AW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r <= {CW{1'b0}};
        if (row_r == ROW_LAST) begin
          row_r <= {AW{1'b0}};
        end else begin
          row_r <= row_r + ROW_ONE;
        end
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      // A request arriving on the wrap cycle itself is honoured immediately.
      if (frame_last_s && (pending_r || swap_req)) begin
        front_sel_r <= ~front_sel_r;
        pending_r   <= 1'b0;
        swap_ack    <= 1'b1;
      end else if (swap_req) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Back-bank row writes; contents survive reset, writes are held off while it is asserted.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_en && wr_ok_s) begin
      if (front_sel_r) begin
        bank0_r[wr_addr] <= wr_data;
      end else begin
        bank1_r[wr_addr] <= wr_data;
      end
    end
  end

  // Registered pin drive: lit row during ON, everything released otherwise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Scan_LED <= SCAN_IDLE;
      Data_LED <= DATA_IDLE;
    end else begin
      case (phase_s)
        PH_ON: begin
          Scan_LED <= row_onehot_s ^ SCAN_IDLE;
          Data_LED <= row_data_s ^ DATA_IDLE;
        end
        PH_BLANK, PH_OFF: begin
          Scan_LED <= SCAN_IDLE;
          Data_LED <= DATA_IDLE;
        end
        default: begin
          Scan_LED <= SCAN_IDLE;
          Data_LED <= DATA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// Bench for dotmatrix_scan_ctrl: a frame-position reference model checks every
// cycle, a vector table checks row display/duty, and hand sequences cover the
// swap, disable and reset corner cases.
module tb_dotmatrix_scan_ctrl;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int SD    = 40;
  localparam int BC    = 8;
  localparam int STEP  = 2;
  localparam int FRAME = ROWS * SD;

  logic       CLK = 1'b0;
  logic       RESET, enable, wr_en, swap_req;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] brightness;
  logic       swap_ack, frame_start;
  logic [7:0] Scan_LED, Data_LED;

  dotmatrix_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .BLANK_CYC(BC),
    .SCAN_ACT_HIGH(1), .DATA_ACT_LOW(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
    .brightness(brightness), .swap_ack(swap_ack), .frame_start(frame_start),
    .Scan_LED(Scan_LED), .Data_LED(Data_LED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame plus two bank images.
  int         m_t;
  int         m_front;
  bit         m_pend;
  int         m_bl;
  logic [7:0] m_bank [2][8];
  logic [7:0] e_scan, e_data;
  logic       e_ack, e_fs;

  typedef struct {
    int         row;
    logic [7:0] d;
    logic [3:0] b;
    logic [3:0] mid_b;
    logic [7:0] e_scan;
    logic [7:0] e_data;
    int         e_len;
    int         e_len_next;
    int         e_first;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cnt, row;
    bit on;
    e_ack = 1'b0; e_fs = 1'b0; e_scan = 8'h00; e_data = 8'hFF;
    if (RESET) begin
      m_t = 0; m_front = 0; m_pend = 1'b0; m_bl = 0;
    end else begin
      if (!enable) begin
        m_t = 0;
        if (swap_req) m_pend = 1'b1;
        if (wr_en) m_bank[1-m_front][wr_addr] = wr_data;
      end else begin
        cnt = m_t % SD;
        row = m_t / SD;
        if (m_t == 0) begin
          m_bl = int'(brightness);
          e_fs = 1'b1;
        end
        on = (cnt >= BC) && ((cnt - BC) < m_bl * STEP);
        if (on) begin
          e_scan = 8'b1 << row;
          e_data = ~m_bank[m_front][row];
        end
        if (wr_en) m_bank[1-m_front][wr_addr] = wr_data;
        if (m_t == FRAME - 1 && (m_pend || swap_req)) begin
          m_front = 1 - m_front;
          m_pend  = 1'b0;
          e_ack   = 1'b1;
        end else if (swap_req) begin
          m_pend = 1'b1;
        end
        m_t = (m_t + 1) % FRAME;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    check("scan", Scan_LED, e_scan);
    check("data", Data_LED, e_data);
    check("swap_ack", swap_ack, e_ack);
    check("frame_start", frame_start, e_fs);
  endtask

  task automatic run_to(input int row, input int cnt);
    int g = 0;
    while (m_t != row * SD + cnt && g < 2 * FRAME) begin
      step();
      g++;
    end
  endtask

  task automatic wait_ack();
    int g = 0;
    while (!swap_ack && g < 2 * FRAME) begin
      step();
      g++;
    end
    check("ack_timeout", swap_ack, 1);
  endtask

  task automatic request_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  initial begin
    int match, total, first, acks, ack_pos, pos, bad;
    vt[0] = '{3, 8'hA5, 4'd15, 4'd15, 8'h08, 8'h5A, 30, 30, 9};
    vt[1] = '{0, 8'h3C, 4'd1,  4'd8,  8'h01, 8'hC3, 2,  16, 9};
    vt[2] = '{7, 8'hFF, 4'd8,  4'd1,  8'h80, 8'h00, 16, 2,  9};
    vt[3] = '{5, 8'h01, 4'd0,  4'd4,  8'h20, 8'hFE, 0,  8,  -1};
    vt[4] = '{2, 8'h80, 4'd4,  4'd0,  8'h04, 8'h7F, 8,  0,  9};
    for (int b = 0; b < 2; b++) for (int r = 0; r < 8; r++) m_bank[b][r] = 8'h00;

    RESET = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = 3'd0;
    wr_data = 8'h00; swap_req = 1'b0; brightness = 4'd0;
    step(); step();
    check("reset_scan", Scan_LED, 8'h00);
    check("reset_data", Data_LED, 8'hFF);

    // Fill both banks with known contents while dark.
    RESET = 1'b0; enable = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < 8; r++) begin
        wr_en = 1'b1; wr_addr = 3'(r); wr_data = 8'($urandom);
        step();
      end
      wr_en = 1'b0;
      request_swap();
      wait_ack();
    end

    // Table: row content, duty length, first lit slot cycle, mid-frame brightness change.
    for (int v = 0; v < 5; v++) begin
      brightness = vt[v].b;
      wr_en = 1'b1; wr_addr = 3'(vt[v].row); wr_data = vt[v].d;
      step();
      wr_en = 1'b0;
      request_swap();
      wait_ack();
      match = 0; total = 0; first = -1;
      for (int k = 0; k < FRAME; k++) begin
        if (k == 120) brightness = vt[v].mid_b;
        step();
        if (Scan_LED != 8'h00) total++;
        if (Scan_LED == vt[v].e_scan && Data_LED == vt[v].e_data) begin
          match++;
          if (first < 0) first = k + 1 - vt[v].row * SD;
        end
      end
      check("on_len", match, vt[v].e_len);
      check("frame_active", total, 8 * vt[v].e_len);
      check("first_on", first, vt[v].e_first);
      match = 0;
      for (int k = 0; k < FRAME; k++) begin
        step();
        if (Scan_LED == vt[v].e_scan && Data_LED == vt[v].e_data) match++;
      end
      check("on_len_next", match, vt[v].e_len_next);
    end

    // Two requests in one frame give one swap, on the last-row wrap.
    brightness = 4'd9;
    run_to(2, 5); request_swap();
    run_to(5, 5); request_swap();
    acks = 0; ack_pos = -1;
    for (int g = 0; g < 2 * FRAME && m_t != SD; g++) begin
      pos = m_t;
      step();
      if (swap_ack) begin acks++; ack_pos = pos; end
    end
    check("swap_once", acks, 1);
    check("swap_at_wrap", ack_pos, FRAME - 1);
    // Request on the wrap cycle itself swaps in that cycle.
    run_to(7, 39);
    request_swap();
    check("swap_same_cycle", swap_ack, 1);
    acks = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (swap_ack) acks++;
    end
    check("no_extra_swap", acks, 0);

    // Disable mid-frame for 100 cycles, with a swap request queued meanwhile.
    brightness = 4'd15;
    run_to(3, 17);
    enable = 1'b0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      if (Scan_LED !== 8'h00 || Data_LED !== 8'hFF || frame_start || swap_ack) bad++;
    end
    check("disabled_idle", bad, 0);
    enable = 1'b1;
    step();
    check("restart_fs", frame_start, 1);
    wait_ack();

    // Reset mid-slot with a swap pending: front returns to bank 0, nothing swaps.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = ~m_bank[m_front][0];
    step();
    wr_en = 1'b0;
    request_swap();
    run_to(4, 20);
    RESET = 1'b1; swap_req = 1'b1;
    step();
    check("rst_mid_scan", Scan_LED, 8'h00);
    check("rst_mid_data", Data_LED, 8'hFF);
    check("rst_mid_ack", swap_ack, 0);
    RESET = 1'b0; swap_req = 1'b0;
    acks = 0; match = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (swap_ack) acks++;
      if (Scan_LED == 8'h01 && Data_LED == ~m_bank[0][0]) match++;
    end
    check("rst_no_swap", acks, 0);
    check("rst_front0", match, 30);

    // Randomized traffic against the model.
    brightness = 4'($urandom);
    for (int i = 0; i < 4000; i++) begin
      RESET    = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 3'($urandom);
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) brightness = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
